xgmii_tx_framer: RTL and testbench

//  Upstream feeder of the XAUI PHY transmit path: converts a valid/ready 64-bit word stream into XGMII

---
 rtl/xgmii_tx_framer.sv | 151 +++++++++++++++
 tb/tb_xgmii_tx_framer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_framer.sv
// xgmii_tx_framer: turns a valid/ready 64-bit word stream into XGMII frames.
// Adds the start/preamble word, the terminate code group and the minimum inter-packet
// gap, and aborts a frame with an error code group if the source runs dry mid-frame.
// Optional build macro XGMII_TX_LINK_GATE_EN adds the xaui_status port and holds new
// frames back until the PHY reports all lanes synced and aligned.
module xgmii_tx_framer #(
    parameter int IPG_WORDS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] tx_data,
    input  logic        tx_valid,
    input  logic        tx_end,
    input  logic [2:0]  tx_bytes,
    output logic        tx_ready,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        tx_underrun,
    output logic [15:0] tx_frames
`ifdef XGMII_TX_LINK_GATE_EN
    ,
    input  logic [7:0]  xaui_status
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_TERM, S_DRAIN, S_IPG} state_t;

    localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
    localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_WORD  = 64'h07070707070707FD;
    localparam logic [63:0] ERROR_WORD = 64'h070707070707FDFE;
    // The IPG state emits IPG_WORDS + 1 idles, so IDLE can launch /S/ on its first cycle
    // and the wire still shows the full minimum gap.
    localparam logic [3:0]  IPG_LAST   = 4'(IPG_WORDS);

    state_t      state_reg, state_next;
    logic [63:0] txd_reg, txd_next;
    logic [7:0]  txc_reg, txc_next;
    logic        underrun_reg, underrun_next;
    logic [15:0] frames_reg, frames_next;
    logic [3:0]  ipg_cnt_reg, ipg_cnt_next;
    logic        link_ok;
    logic [63:0] partial_word;
    logic [7:0]  partial_txc;

`ifdef XGMII_TX_LINK_GATE_EN
    logic unused_status;
    assign unused_status = ^{xaui_status[7], xaui_status[1:0]};
    assign link_ok = (xaui_status[6:2] == 5'b11111);
`else
    assign link_ok = 1'b1;
`endif

    // Short last word: data in lanes below tx_bytes, /T/ in lane tx_bytes, idle above.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [2:0] LANE = 3'(gi);
            assign partial_word[8*gi +: 8] = (LANE < tx_bytes)  ? tx_data[8*gi +: 8] :
                                             (LANE == tx_bytes) ? 8'hFD : 8'h07;
        end
    endgenerate
    assign partial_txc = 8'hFF << tx_bytes;

    assign tx_ready    = (state_reg == S_DATA) || (state_reg == S_DRAIN);
    assign xgmii_txd   = txd_reg;
    assign xgmii_txc   = txc_reg;
    assign tx_underrun = underrun_reg;
    assign tx_frames   = frames_reg;

    // Next-state and next output word; idle word is the default load in every state.
    always_comb begin
        state_next    = state_reg;
        txd_next      = IDLE_WORD;
        txc_next      = 8'hFF;
        underrun_next = 1'b0;
        frames_next   = frames_reg;
        ipg_cnt_next  = ipg_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (tx_valid && link_ok) begin
                    txd_next   = START_WORD;
                    txc_next   = 8'h01;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_valid) begin
                    if (!tx_end) begin
                        txd_next = tx_data;
                        txc_next = 8'h00;
                    end else if (tx_bytes == 3'd0) begin
                        txd_next   = tx_data;
                        txc_next   = 8'h00;
                        state_next = S_TERM;
                    end else begin
                        txd_next    = partial_word;
                        txc_next    = partial_txc;
                        frames_next = frames_reg + 16'd1;
                        state_next  = S_IPG;
                    end
                end else begin
                    // Source ran dry mid-frame: poison the frame and swallow the rest of it.
                    txd_next      = ERROR_WORD;
                    txc_next      = 8'hFF;
                    underrun_next = 1'b1;
                    state_next    = S_DRAIN;
                end
            end
            S_TERM: begin
                txd_next    = TERM_WORD;
                txc_next    = 8'hFF;
                frames_next = frames_reg + 16'd1;
                state_next  = S_IPG;
            end
            S_DRAIN: begin
                if (tx_valid && tx_end) begin
                    state_next = S_IPG;
                end
            end
            S_IPG: begin
                if (ipg_cnt_reg == IPG_LAST) begin
                    ipg_cnt_next = 4'd0;
                    state_next   = S_IDLE;
                end else begin
                    ipg_cnt_next = ipg_cnt_reg + 4'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, output word and counters; the underrun pulse lines up with the error word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            txd_reg      <= IDLE_WORD;
            txc_reg      <= 8'hFF;
            underrun_reg <= 1'b0;
            frames_reg   <= 16'd0;
            ipg_cnt_reg  <= 4'd0;
        end else begin
            state_reg    <= state_next;
            txd_reg      <= txd_next;
            txc_reg      <= txc_next;
            underrun_reg <= underrun_next;
            frames_reg   <= frames_next;
            ipg_cnt_reg  <= ipg_cnt_next;
        end
    end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Directed bench for xgmii_tx_framer with hand-computed wire words.
module tb_xgmii_tx_framer;

    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
    localparam logic [63:0] ERROR_W = 64'h070707070707FDFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] tx_data = 64'h0;
    logic        tx_valid = 1'b0;
    logic        tx_end = 1'b0;
    logic [2:0]  tx_bytes = 3'd0;
    logic        tx_ready;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        tx_underrun;
    logic [15:0] tx_frames;
`ifdef XGMII_TX_LINK_GATE_EN
    logic [7:0]  xaui_status = 8'h7C;
`endif

    int checks = 0;
    int passes = 0;

    xgmii_tx_framer #(.IPG_WORDS(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_end      (tx_end),
        .tx_bytes    (tx_bytes),
        .tx_ready    (tx_ready),
        .xgmii_txd   (xgmii_txd),
        .xgmii_txc   (xgmii_txc),
        .tx_underrun (tx_underrun),
        .tx_frames   (tx_frames)
`ifdef XGMII_TX_LINK_GATE_EN
        ,
        .xaui_status (xaui_status)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_wire(input string tag, input logic [63:0] d, input logic [7:0] c);
        $display("%0t %s txd=%h txc=%h ready=%b urun=%b frames=%h",
                 $time, tag, xgmii_txd, xgmii_txc, tx_ready, tx_underrun, tx_frames);
        chk({tag, ".txd"}, xgmii_txd, d);
        chk({tag, ".txc"}, {56'h0, xgmii_txc}, {56'h0, c});
    endtask

    task automatic set_in(input logic v, input logic [63:0] d, input logic e, input logic [2:0] b);
        tx_valid = v;
        tx_data  = d;
        tx_end   = e;
        tx_bytes = b;
    endtask

    int gap;

    initial begin
        // 1: reset held, outputs idle every cycle
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_wire("rst", IDLE_W, 8'hFF);
            chk("rst.ready", {63'h0, tx_ready}, 64'h0);
            chk("rst.frames", {48'h0, tx_frames}, 64'h0);
        end
        reset = 1'b0;
        tick();
        chk_wire("idle", IDLE_W, 8'hFF);

        // 2: three full words, terminate in its own word
        set_in(1'b1, 64'h1111111111111111, 1'b0, 3'd0);
        tick(); chk_wire("f2.start", START_W, 8'h01);
        chk("f2.ready", {63'h0, tx_ready}, 64'h1);
        tick(); chk_wire("f2.d0", 64'h1111111111111111, 8'h00);
        set_in(1'b1, 64'h2222222222222222, 1'b0, 3'd0);
        tick(); chk_wire("f2.d1", 64'h2222222222222222, 8'h00);
        set_in(1'b1, 64'h3333333333333333, 1'b1, 3'd0);
        tick(); chk_wire("f2.d2", 64'h3333333333333333, 8'h00);
        set_in(1'b0, 64'h0, 1'b0, 3'd0);
        tick(); chk_wire("f2.term", TERM_W, 8'hFF);
        chk("f2.frames", {48'h0, tx_frames}, 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_wire("f2.ipg", IDLE_W, 8'hFF);
        end
        chk("f2.ready_ipg", {63'h0, tx_ready}, 64'h0);

        // 3: two words, last holds 5 bytes
        reset = 1'b1; tick(); reset = 1'b0;
        set_in(1'b1, 64'h0123456789ABCDEF, 1'b0, 3'd0);
        tick(); chk_wire("f3.start", START_W, 8'h01);
        tick(); chk_wire("f3.d0", 64'h0123456789ABCDEF, 8'h00);
        set_in(1'b1, 64'hFEDCBA9876543210, 1'b1, 3'd5);
        tick(); chk_wire("f3.last", 64'h0707FD9876543210, 8'hE0);
        chk("f3.frames", {48'h0, tx_frames}, 64'h1);
        set_in(1'b0, 64'h0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_wire("f3.ipg", IDLE_W, 8'hFF);
        end

        // 4: underrun after first data word, two trailing words discarded
        set_in(1'b1, 64'hAAAAAAAAAAAAAAAA, 1'b0, 3'd0);
        tick(); chk_wire("f4.start", START_W, 8'h01);
        tick(); chk_wire("f4.d0", 64'hAAAAAAAAAAAAAAAA, 8'h00);
        set_in(1'b0, 64'h0, 1'b0, 3'd0);
        tick(); chk_wire("f4.err", ERROR_W, 8'hFF);
        chk("f4.urun", {63'h0, tx_underrun}, 64'h1);
        set_in(1'b1, 64'hBBBBBBBBBBBBBBBB, 1'b0, 3'd0);
        tick(); chk_wire("f4.drain0", IDLE_W, 8'hFF);
        chk("f4.urun_off", {63'h0, tx_underrun}, 64'h0);
        chk("f4.drain_ready", {63'h0, tx_ready}, 64'h1);
        set_in(1'b1, 64'hCCCCCCCCCCCCCCCC, 1'b1, 3'd0);
        tick(); chk_wire("f4.drain1", IDLE_W, 8'hFF);
        chk("f4.ipg_ready", {63'h0, tx_ready}, 64'h0);
        set_in(1'b0, 64'h0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("f4.frames", {48'h0, tx_frames}, 64'h1);

        // reset in the middle of a frame: idle next, no terminate, counter cleared
        set_in(1'b1, 64'hDDDDDDDDDDDDDDDD, 1'b0, 3'd0);
        tick(); chk_wire("mr.start", START_W, 8'h01);
        tick(); chk_wire("mr.d0", 64'hDDDDDDDDDDDDDDDD, 8'h00);
        reset = 1'b1;
        tick(); chk_wire("mr.rst", IDLE_W, 8'hFF);
        chk("mr.frames", {48'h0, tx_frames}, 64'h0);
        reset = 1'b0;
        set_in(1'b0, 64'h0, 1'b0, 3'd0);
        tick(); chk_wire("mr.after", IDLE_W, 8'hFF);

        // 5: back-to-back single-word frames with tx_valid held
        set_in(1'b1, 64'hAABBCCDDEEFF1122, 1'b1, 3'd3);
        tick(); chk_wire("b2b.start", START_W, 8'h01);
        tick(); chk_wire("b2b.last", 64'h07070707FDFF1122, 8'hF8);
        for (int f = 0; f < 2; f++) begin
            gap = 0;
            tick();
            while (xgmii_txd === IDLE_W && gap < 20) begin
                gap++;
                tick();
            end
            chk("b2b.gap", 64'(gap), 64'd3);
            chk_wire("b2b.start", START_W, 8'h01);
            tick(); chk_wire("b2b.last", 64'h07070707FDFF1122, 8'hF8);
        end
        set_in(1'b0, 64'h0, 1'b0, 3'd0);
        chk("b2b.frames", {48'h0, tx_frames}, 64'h3);
        for (int i = 0; i < 4; i++) tick();

`ifdef XGMII_TX_LINK_GATE_EN
        // 6a: link gate holds the frame back until lanes are aligned
        xaui_status = 8'h78;
        set_in(1'b1, 64'h5A5A5A5A5A5A5A5A, 1'b1, 3'd0);
        tick(); chk_wire("lg.down0", IDLE_W, 8'hFF);
        tick(); chk_wire("lg.down1", IDLE_W, 8'hFF);
        chk("lg.ready", {63'h0, tx_ready}, 64'h0);
        xaui_status = 8'h7C;
        tick(); chk_wire("lg.start", START_W, 8'h01);
        xaui_status = 8'h00;
        tick(); chk_wire("lg.d0", 64'h5A5A5A5A5A5A5A5A, 8'h00);
        set_in(1'b0, 64'h0, 1'b0, 3'd0);
        tick(); chk_wire("lg.term", TERM_W, 8'hFF);
        chk("lg.frames", {48'h0, tx_frames}, 64'h4);
        xaui_status = 8'h7C;
        for (int i = 0; i < 4; i++) tick();
`endif

        // 6b: frame counter wraps from FFFF to 0000
        force dut.frames_reg = 16'hFFFF;
        #1;
        release dut.frames_reg;
        tick();
        chk("wrap.pre", {48'h0, tx_frames}, 64'hFFFF);
        set_in(1'b1, 64'h9999999999999999, 1'b1, 3'd0);
        tick(); chk_wire("wrap.start", START_W, 8'h01);
        tick(); chk_wire("wrap.d0", 64'h9999999999999999, 8'h00);
        set_in(1'b0, 64'h0, 1'b0, 3'd0);
        tick(); chk_wire("wrap.term", TERM_W, 8'hFF);
        chk("wrap.frames", {48'h0, tx_frames}, 64'h0);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
